// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - input/output handshake bundle for the immediate-extension pipe
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  // master drives the unit (producer of immediates, consumer of results)
  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - two-stage valid/ready immediate extender (ZEXT/SEXT/BRANCH/UPPER)
module imm_extend_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int SHIFT_AMT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  imm_extend_pipe_if.slave     io
);
  localparam int PAD = OUT_W - IN_W;

  localparam logic [1:0] MODE_ZEXT   = 2'd0;
  localparam logic [1:0] MODE_SEXT   = 2'd1;
  localparam logic [1:0] MODE_BRANCH = 2'd2;
  localparam logic [1:0] MODE_UPPER  = 2'd3;

  generate
    if (IN_W < 2) begin : g_bad_in_w
      $error("imm_extend_pipe: IN_W must be >= 2");
    end
    if (OUT_W <= IN_W) begin : g_bad_out_w
      $error("imm_extend_pipe: OUT_W must exceed IN_W");
    end
    if (SHIFT_AMT >= OUT_W - IN_W) begin : g_bad_shift
      $error("imm_extend_pipe: SHIFT_AMT must be below OUT_W - IN_W");
    end
  endgenerate

  logic             a_valid_q, a_valid_d;
  logic [IN_W-1:0]  a_imm_q, a_imm_d;
  logic [1:0]       a_mode_q, a_mode_d;
  logic             b_valid_q, b_valid_d;
  logic [OUT_W-1:0] b_data_q, b_data_d;
  logic [1:0]       b_mode_q, b_mode_d;

  logic             b_take;
  logic             in_xfer;
  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] a_ext;

  assign b_take      = !b_valid_q || io.out_ready;
  assign io.in_ready = !a_valid_q || b_take;
  assign in_xfer     = io.in_valid && io.in_ready;

  assign sext_val = {{PAD{a_imm_q[IN_W-1]}}, a_imm_q};

  always_comb begin
    a_ext = '0;
    case (a_mode_q)
      MODE_ZEXT:   a_ext = {{PAD{1'b0}}, a_imm_q};
      MODE_SEXT:   a_ext = sext_val;
      MODE_BRANCH: a_ext = sext_val << SHIFT_AMT;
      MODE_UPPER:  a_ext = {a_imm_q, {PAD{1'b0}}};
      default:     a_ext = '0;
    endcase
  end

  // flush wins over every load; datapath registers keep their last value
  always_comb begin
    a_valid_d = a_valid_q;
    a_imm_d   = a_imm_q;
    a_mode_d  = a_mode_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_mode_d  = b_mode_q;

    if (a_valid_q && b_take) begin
      b_valid_d = 1'b1;
      b_data_d  = a_ext;
      b_mode_d  = a_mode_q;
    end else if (b_valid_q && io.out_ready) begin
      b_valid_d = 1'b0;
    end

    if (in_xfer) begin
      a_valid_d = 1'b1;
      a_imm_d   = io.in_imm;
      a_mode_d  = io.in_mode;
    end else if (a_valid_q && b_take) begin
      a_valid_d = 1'b0;
    end

    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
      a_imm_d   = a_imm_q;
      a_mode_d  = a_mode_q;
      b_data_d  = b_data_q;
      b_mode_d  = b_mode_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_imm_q   <= '0;
      a_mode_q  <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_mode_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_imm_q   <= a_imm_d;
      a_mode_q  <= a_mode_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_mode_q  <= b_mode_d;
    end
  end

  assign io.out_valid = b_valid_q;
  assign io.out_data  = b_data_q;
  assign io.out_mode  = b_mode_q;
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Pipelined, parametrised immediate-extension unit for the CPU datapath. It takes an IN_W-bit immediate field plus a mode code, and produces an OUT_W-bit operand in one of four modes: zero-extend, sign-extend, shifted sign-extend (branch offset) or load-upper. It sits between instruction decode and the ALU operand mux. Flow control is valid/ready with full backpressure, and the unit sustains one result per cycle.

Parameters:
IN_W, 16, width of immediate input; must be ≥ 2.
OUT_W, 32, width of extended output; must be > IN_W.
SHIFT_AMT, 2, left-shift applied in branch mode; must be < OUT_W - IN_W.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous pipeline flush.
in_valid  input  1  input transfer request.
in_ready  output  1  unit can accept input this cycle.
in_imm  input  IN_W  immediate field.
in_mode  input  2  0=ZEXT, 1=SEXT, 2=BRANCH, 3=UPPER.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_data  output  OUT_W  extended result.
out_mode  output  2  mode tag travelling with the result.

Behaviour:
- Reset (async, rst=1): stage-A and stage-B valid flags clear immediately. out_valid=0, out_data=0, out_mode=0. in_ready=1 once rst deasserts.
- Stage A registers in_imm/in_mode on input transfer (in_valid && in_ready). Stage B registers the computed result.
- Arithmetic, all results exactly OUT_W bits:
  - ZEXT: {(OUT_W-IN_W) zeros, in_imm}.
  - SEXT: {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
  - BRANCH: SEXT value shifted left by SHIFT_AMT, upper bits discarded, low SHIFT_AMT bits zero.
  - UPPER: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], all lower bits zero.
- Handshake:
  - b_take = !b_valid || out_ready.
  - in_ready = !a_valid || b_take. in_ready is combinational from state and out_ready only; it never depends on in_valid.
  - When a_valid && b_take: stage B loads A's result, b_valid=1.
  - When b_valid && out_ready && !(a_valid): b_valid=0.
  - Stage A loads on input transfer. Otherwise it clears when its content moves to B.
- Latency: input transfer in cycle N gives out_valid=1 in cycle N+2 if no stall. Throughput is 1 per cycle under continuous out_ready=1.
- Stall: while out_valid && !out_ready, out_data and out_mode hold stable. With both stages full, in_ready=0. No transfer is dropped or duplicated.
- Simultaneous events:
  - Input transfer with A draining to B in the same cycle: both occur.
  - Output transfer with B refill in the same cycle: out_valid stays 1 and new data appears next cycle.
- flush=1 at an edge: a_valid and b_valid clear. Any input presented that cycle is dropped, even if in_ready=1. flush has priority over all loads. out_data keeps its last value; it is don't-care while out_valid=0.
- Reset mid-operation: in-flight items are discarded with no output. The first post-reset input behaves as from idle.
- Illegal parameters (OUT_W ≤ IN_W, SHIFT_AMT ≥ OUT_W-IN_W) fail elaboration via a generate-time check.

Test Plan:
1. Defaults, out_ready=1. Inputs: 0x8001 SEXT, then 0x8001 ZEXT, then 0x7FFF SEXT on consecutive cycles -> out_data 0xFFFF8001, 0x00008001, 0x00007FFF on cycles N+2, N+3, N+4, each with out_mode echoed.
2. BRANCH 0xFFFF -> 0xFFFFFFFC. BRANCH 0x4000 -> 0x00010000. UPPER 0x1234 -> 0x12340000. UPPER 0xFFFF -> 0xFFFF0000.
3. Backpressure: hold out_ready=0 and stream 3 inputs -> in_ready drops after 2 accepts; out_data stays at the first result. Release out_ready -> results emerge in order, one per cycle, none lost.
4. Flush with both stages full and in_valid=1 -> next cycle out_valid=0 and in_ready=1. The item offered during flush never appears.
5. Assert rst asynchronously mid-stream (between edges) -> out_valid falls without a clock edge. After release, 0x0001 ZEXT -> 0x00000001 at 2-cycle latency.
6. Parameter variant IN_W=12, OUT_W=32, SHIFT_AMT=1: BRANCH 0x800 -> 0xFFFFF000; SEXT 0x7FF -> 0x000007FF.
